// File: rtl/stack_alu_pkg.sv
// Shared definitions for the stack ALU and the RPN sequencer that drives it.
// Contents: ALU opcode encodings, sequencer error codes, sequencer FSM states.
package stack_alu_pkg;

  localparam logic [2:0] OP_NOP  = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_PUSH = 3'b110;
  localparam logic [2:0] OP_POP  = 3'b111;

  localparam logic [1:0] ERR_ALU_FAIL  = 2'b00;
  localparam logic [1:0] ERR_UNDERFLOW = 2'b01;
  localparam logic [1:0] ERR_FULL      = 2'b10;
  localparam logic [1:0] ERR_DEPTH     = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PUSH,
    S_ARITH,
    S_CAPT,
    S_POP_A,
    S_POP_B,
    S_PUSH_R,
    S_FIN_POP,
    S_FIN_CAPT,
    S_ERR_DRAIN,
    S_ERR_SKIP
  } seq_state_e;

endpackage

// File: rtl/rpn_sequencer.sv
// RPN sequencer: turns a valid/ready token stream (operands and add/mul
// operators) into the opcode sequence for a stack ALU, then pops the final
// value and reports it, or reports a malformed expression as an error.
// Ports:
//   clk, rst (async, active low)
//   tok_valid/tok_ready handshake; tok_is_op, tok_op, tok_value, tok_last
//   alu_opcode, alu_input_data -> ALU; alu_output_data, alu_overflow,
//   alu_success <- ALU
//   result, result_valid, result_ovf, error, error_code -> consumer
//
// state      | meaning
// -----------+----------------------------------------------------------
// IDLE       | waiting for a token, ALU idle
// PUSH       | operand push on the ALU bus
// ARITH      | add/mul on the ALU bus
// CAPT       | ALU result visible; latch it and the overflow flag
// POP_A      | pop first operand
// POP_B      | pop second operand
// PUSH_R     | push the captured result
// FIN_POP    | pop the final value
// FIN_CAPT   | final value visible; publish result
// ERR_DRAIN  | pop until the tracked depth is zero
// ERR_SKIP   | swallow tokens through tok_last, then report error
module rpn_sequencer
  import stack_alu_pkg::*;
#(
  parameter int N        = 4,
  parameter int MAX_SIZE = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                tok_valid,
  output logic                tok_ready,
  input  logic                tok_is_op,
  input  logic                tok_op,
  input  logic signed [N-1:0] tok_value,
  input  logic                tok_last,
  output logic [2:0]          alu_opcode,
  output logic signed [N-1:0] alu_input_data,
  input  logic signed [N-1:0] alu_output_data,
  input  logic                alu_overflow,
  input  logic                alu_success,
  output logic signed [N-1:0] result,
  output logic                result_valid,
  output logic                result_ovf,
  output logic                error,
  output logic [1:0]          error_code
);

  localparam int DW = $clog2(MAX_SIZE + 1);
  localparam logic [DW-1:0] DEPTH_MAX = DW'(MAX_SIZE);
  localparam logic [DW-1:0] ONE       = DW'(1);
  localparam logic [DW-1:0] TWO       = DW'(2);

  seq_state_e          state, state_nxt;
  logic [DW-1:0]       depth, depth_nxt;
  logic                last_pend, last_pend_nxt;
  logic                skip_pend, skip_pend_nxt;
  logic [1:0]          err_pend, err_pend_nxt;
  logic                sticky, sticky_nxt;
  logic signed [N-1:0] temp, temp_nxt;
  logic [2:0]          opcode_nxt;
  logic signed [N-1:0] data_nxt;
  logic signed [N-1:0] result_nxt;
  logic                result_valid_nxt, result_ovf_nxt;
  logic                error_nxt;
  logic [1:0]          error_code_nxt;
  logic                tok_acc;

  // Gated by rst so the upstream sees not-ready while reset is held.
  assign tok_ready = rst & ((state == S_IDLE) | (state == S_ERR_SKIP));
  assign tok_acc   = tok_valid & tok_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= S_IDLE;
      depth          <= '0;
      last_pend      <= 1'b0;
      skip_pend      <= 1'b0;
      err_pend       <= ERR_ALU_FAIL;
      sticky         <= 1'b0;
      temp           <= '0;
      alu_opcode     <= OP_NOP;
      alu_input_data <= '0;
      result         <= '0;
      result_valid   <= 1'b0;
      result_ovf     <= 1'b0;
      error          <= 1'b0;
      error_code     <= ERR_ALU_FAIL;
    end else begin
      state          <= state_nxt;
      depth          <= depth_nxt;
      last_pend      <= last_pend_nxt;
      skip_pend      <= skip_pend_nxt;
      err_pend       <= err_pend_nxt;
      sticky         <= sticky_nxt;
      temp           <= temp_nxt;
      alu_opcode     <= opcode_nxt;
      alu_input_data <= data_nxt;
      result         <= result_nxt;
      result_valid   <= result_valid_nxt;
      result_ovf     <= result_ovf_nxt;
      error          <= error_nxt;
      error_code     <= error_code_nxt;
    end
  end

  // depth mirrors the ALU stack occupancy: it moves when a push/pop is
  // issued, so a drain from any state pops exactly what the ALU holds.
  always_comb begin
    state_nxt        = state;
    depth_nxt        = depth;
    last_pend_nxt    = last_pend;
    skip_pend_nxt    = skip_pend;
    err_pend_nxt     = err_pend;
    sticky_nxt       = sticky;
    temp_nxt         = temp;
    opcode_nxt       = OP_NOP;
    data_nxt         = alu_input_data;
    result_nxt       = result;
    result_valid_nxt = 1'b0;
    result_ovf_nxt   = result_ovf;
    error_nxt        = 1'b0;
    error_code_nxt   = error_code;

    case (state)
      S_IDLE: begin
        if (tok_acc) begin
          last_pend_nxt = tok_last;
          skip_pend_nxt = !tok_last;
          if (!tok_is_op) begin
            if (depth == DEPTH_MAX) begin
              state_nxt    = S_ERR_DRAIN;
              err_pend_nxt = ERR_FULL;
            end else begin
              state_nxt  = S_PUSH;
              opcode_nxt = OP_PUSH;
              data_nxt   = tok_value;
              depth_nxt  = depth + ONE;
            end
          end else if (depth < TWO) begin
            state_nxt    = S_ERR_DRAIN;
            err_pend_nxt = ERR_UNDERFLOW;
          end else begin
            state_nxt  = S_ARITH;
            opcode_nxt = tok_op ? OP_MUL : OP_ADD;
          end
        end
      end
      S_PUSH, S_PUSH_R: begin
        if (!last_pend) begin
          state_nxt = S_IDLE;
        end else if (depth != ONE) begin
          state_nxt     = S_ERR_DRAIN;
          err_pend_nxt  = ERR_DEPTH;
          skip_pend_nxt = 1'b0;
        end else begin
          state_nxt  = S_FIN_POP;
          opcode_nxt = OP_POP;
          depth_nxt  = depth - ONE;
        end
      end
      S_ARITH: state_nxt = S_CAPT;
      S_CAPT: begin
        if (!alu_success) begin
          state_nxt     = S_ERR_DRAIN;
          err_pend_nxt  = ERR_ALU_FAIL;
          skip_pend_nxt = !last_pend;
        end else begin
          temp_nxt   = alu_output_data;
          sticky_nxt = sticky | alu_overflow;
          state_nxt  = S_POP_A;
          opcode_nxt = OP_POP;
          depth_nxt  = depth - ONE;
        end
      end
      S_POP_A: begin
        state_nxt  = S_POP_B;
        opcode_nxt = OP_POP;
        depth_nxt  = depth - ONE;
      end
      S_POP_B: begin
        state_nxt  = S_PUSH_R;
        opcode_nxt = OP_PUSH;
        data_nxt   = temp;
        depth_nxt  = depth + ONE;
      end
      S_FIN_POP: state_nxt = S_FIN_CAPT;
      S_FIN_CAPT: begin
        if (!alu_success) begin
          state_nxt     = S_ERR_DRAIN;
          err_pend_nxt  = ERR_ALU_FAIL;
          skip_pend_nxt = 1'b0;
        end else begin
          result_nxt       = alu_output_data;
          result_valid_nxt = 1'b1;
          result_ovf_nxt   = sticky;
          sticky_nxt       = 1'b0;
          state_nxt        = S_IDLE;
        end
      end
      S_ERR_DRAIN: begin
        if (depth != '0) begin
          opcode_nxt = OP_POP;
          depth_nxt  = depth - ONE;
        end else if (skip_pend) begin
          state_nxt = S_ERR_SKIP;
        end else begin
          error_nxt      = 1'b1;
          error_code_nxt = err_pend;
          sticky_nxt     = 1'b0;
          state_nxt      = S_IDLE;
        end
      end
      S_ERR_SKIP: begin
        if (tok_acc && tok_last) begin
          error_nxt      = 1'b1;
          error_code_nxt = err_pend;
          sticky_nxt     = 1'b0;
          state_nxt      = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// Self-checking bench for rpn_sequencer with a behavioural stack ALU model.
module tb_rpn_sequencer;
  import stack_alu_pkg::*;

  localparam int N = 4;
  localparam int MAX_SIZE = 1024;
  localparam logic [7:0] T_ADD = 8'h80;
  localparam logic [7:0] T_MUL = 8'hC0;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tok_valid = 1'b0, tok_is_op = 1'b0, tok_op = 1'b0, tok_last = 1'b0;
  logic signed [N-1:0] tok_value = '0;
  logic tok_ready;
  logic [2:0] alu_opcode;
  logic signed [N-1:0] alu_input_data, alu_output_data, result;
  logic alu_overflow, alu_success;
  logic result_valid, result_ovf, error;
  logic [1:0] error_code;

  always #5 clk = ~clk;

  rpn_sequencer #(.N(N), .MAX_SIZE(MAX_SIZE)) dut (
    .clk(clk), .rst(rst),
    .tok_valid(tok_valid), .tok_ready(tok_ready), .tok_is_op(tok_is_op),
    .tok_op(tok_op), .tok_value(tok_value), .tok_last(tok_last),
    .alu_opcode(alu_opcode), .alu_input_data(alu_input_data),
    .alu_output_data(alu_output_data), .alu_overflow(alu_overflow),
    .alu_success(alu_success),
    .result(result), .result_valid(result_valid), .result_ovf(result_ovf),
    .error(error), .error_code(error_code)
  );

  // ---------------- ALU model ----------------
  logic [3:0] stk [0:MAX_SIZE-1];
  int sp = 0;
  logic force_fail = 1'b0;

  function automatic logic [4:0] alu_arith(input logic mul,
                                           input logic signed [3:0] a,
                                           input logic signed [3:0] b);
    logic signed [7:0] wa, wb, w;
    logic ovf;
    wa = a;
    wb = b;
    w = mul ? wa * wb : wa + wb;
    ovf = (w > 8'sd7) || (w < -8'sd8);
    return {ovf, w[3:0]};
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sp <= 0;
      alu_output_data <= '0;
      alu_overflow <= 1'b0;
      alu_success <= 1'b0;
    end else begin
      case (alu_opcode)
        OP_PUSH: begin
          if (sp < MAX_SIZE) begin
            stk[sp] <= alu_input_data;
            sp <= sp + 1;
            alu_success <= 1'b1;
          end else alu_success <= 1'b0;
        end
        OP_POP: begin
          if (sp > 0) begin
            alu_output_data <= stk[sp-1];
            sp <= sp - 1;
            alu_success <= 1'b1;
          end else alu_success <= 1'b0;
        end
        OP_ADD, OP_MUL: begin
          if (sp >= 2) begin
            alu_output_data <= alu_arith(alu_opcode[0], stk[sp-1], stk[sp-2]) & 5'h0F;
            alu_overflow <= alu_arith(alu_opcode[0], stk[sp-1], stk[sp-2]) >> 4;
            alu_success <= !force_fail;
          end else alu_success <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  // ---------------- monitors ----------------
  int pop_total = 0;
  int done_cnt = 0;
  logic cap_err = 1'b0;
  logic [3:0] cap_res = '0;
  logic cap_ovf = 1'b0;
  logic [1:0] cap_code = '0;
  logic both_seen = 1'b0;

  always @(posedge clk)
    if (rst && alu_opcode == OP_POP) pop_total <= pop_total + 1;

  always @(negedge clk) begin
    if (result_valid) begin
      done_cnt <= done_cnt + 1;
      cap_err <= 1'b0;
      cap_res <= result;
      cap_ovf <= result_ovf;
    end
    if (error) begin
      done_cnt <= done_cnt + 1;
      cap_err <= 1'b1;
      cap_code <= error_code;
    end
    if (result_valid && error) both_seen <= 1'b1;
  end

  // ---------------- checking ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_tok(input logic [7:0] t, input logic last);
    int n = 0;
    tok_valid = 1'b1;
    tok_is_op = t[7];
    tok_op = t[6];
    tok_value = t[3:0];
    tok_last = last;
    while (!tok_ready && n < 50) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      chk("tok_accept_timeout", 16'(n), 16'd0);
    end else begin
      @(posedge clk); #1;
    end
    tok_valid = 1'b0;
    tok_last = 1'b0;
  endtask

  task automatic wait_done(input int snap, input string name);
    int n = 0;
    while (done_cnt == snap && n < 100) begin
      @(negedge clk); #1;
      n++;
    end
    if (n >= 100) chk({name, "_timeout"}, 16'(n), 16'd0);
  endtask

  typedef struct {
    int n;
    logic [4:0][7:0] tok;
    logic err;
    logic [1:0] code;
    logic [3:0] res;
    logic ovf;
    int pops;
    logic ff;
  } vec_t;

  function automatic vec_t mk(input int n, input logic [7:0] t0, t1, t2, t3, t4,
                              input logic err, input logic [1:0] code,
                              input logic [3:0] res, input logic ovf,
                              input int pops, input logic ff);
    vec_t v;
    v.n = n;
    v.tok[0] = t0; v.tok[1] = t1; v.tok[2] = t2; v.tok[3] = t3; v.tok[4] = t4;
    v.err = err; v.code = code; v.res = res; v.ovf = ovf; v.pops = pops; v.ff = ff;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input int idx);
    int snap_done = done_cnt;
    int snap_pop = pop_total;
    force_fail = v.ff;
    for (int i = 0; i < v.n; i++) send_tok(v.tok[i], i == v.n - 1);
    wait_done(snap_done, $sformatf("v%0d", idx));
    force_fail = 1'b0;
    chk($sformatf("v%0d_kind", idx), 16'(cap_err), 16'(v.err));
    if (v.err) begin
      chk($sformatf("v%0d_code", idx), 16'(cap_code), 16'(v.code));
    end else begin
      chk($sformatf("v%0d_result", idx), 16'(cap_res), 16'(v.res));
      chk($sformatf("v%0d_ovf", idx), 16'(cap_ovf), 16'(v.ovf));
    end
    chk($sformatf("v%0d_pops", idx), 16'(pop_total - snap_pop), 16'(v.pops));
    chk($sformatf("v%0d_alu_depth", idx), 16'(sp), 16'd0);
  endtask

  vec_t vecs [12];

  initial begin
    int lows;
    int snap;
    vecs[0]  = mk(3, 8'h03, 8'h04, T_ADD, 8'h00, 8'h00, 0, 2'b00, 4'h7, 0, 3, 0);
    vecs[1]  = mk(3, 8'h03, 8'h04, T_MUL, 8'h00, 8'h00, 0, 2'b00, 4'hC, 1, 3, 0);
    vecs[2]  = mk(5, 8'h02, 8'h03, T_ADD, 8'h05, T_MUL, 0, 2'b00, 4'h9, 1, 5, 0);
    vecs[3]  = mk(3, 8'h05, T_ADD, 8'h07, 8'h00, 8'h00, 1, 2'b01, 4'h0, 0, 1, 0);
    vecs[4]  = mk(3, 8'h01, 8'h01, T_ADD, 8'h00, 8'h00, 0, 2'b00, 4'h2, 0, 3, 0);
    vecs[5]  = mk(2, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 1, 2'b11, 4'h0, 0, 2, 0);
    vecs[6]  = mk(3, 8'h08, 8'h0F, T_ADD, 8'h00, 8'h00, 0, 2'b00, 4'h7, 1, 3, 0);
    vecs[7]  = mk(1, 8'h07, 8'h00, 8'h00, 8'h00, 8'h00, 0, 2'b00, 4'h7, 0, 1, 0);
    vecs[8]  = mk(1, T_ADD, 8'h00, 8'h00, 8'h00, 8'h00, 1, 2'b01, 4'h0, 0, 0, 0);
    vecs[9]  = mk(5, 8'h03, 8'h04, T_MUL, 8'h00, T_ADD, 0, 2'b00, 4'hC, 1, 5, 0);
    vecs[10] = mk(3, 8'h01, 8'h02, T_ADD, 8'h00, 8'h00, 0, 2'b00, 4'h3, 0, 3, 0);
    vecs[11] = mk(3, 8'h01, 8'h02, T_ADD, 8'h00, 8'h00, 1, 2'b00, 4'h0, 0, 2, 1);

    // Reset state
    #12;
    chk("rst_tok_ready", 16'(tok_ready), 16'd0);
    chk("rst_opcode", 16'(alu_opcode), 16'(OP_NOP));
    chk("rst_result_valid", 16'(result_valid), 16'd0);
    chk("rst_error_code", 16'(error_code), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("idle_tok_ready", 16'(tok_ready), 16'd1);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

    // tok_ready low for the whole operator sequence: 5 cycles, +2 when last
    snap = done_cnt;
    send_tok(8'h02, 1'b0);
    send_tok(8'h03, 1'b0);
    send_tok(T_ADD, 1'b0);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (tok_ready) break;
      lows++;
    end
    chk("ready_low_op", 16'(lows), 16'd5);
    send_tok(8'h05, 1'b0);
    send_tok(T_MUL, 1'b1);
    lows = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk); #1;
      if (tok_ready) break;
      lows++;
    end
    chk("ready_low_last_op", 16'(lows), 16'd7);
    wait_done(snap, "seq_ready");
    chk("seq_ready_result", 16'(cap_res), 16'h9);

    // Reset during POP_B of 3,4,+
    send_tok(8'h03, 1'b0);
    send_tok(8'h04, 1'b0);
    send_tok(T_ADD, 1'b1);
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_opcode", 16'(alu_opcode), 16'(OP_NOP));
    chk("mid_rst_data", 16'(alu_input_data), 16'd0);
    chk("mid_rst_tok_ready", 16'(tok_ready), 16'd0);
    chk("mid_rst_result", 16'(result), 16'd0);
    chk("mid_rst_flags", 16'({result_valid, result_ovf, error}), 16'd0);
    chk("mid_rst_error_code", 16'(error_code), 16'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post_rst_tok_ready", 16'(tok_ready), 16'd1);
    run_vec(vecs[4], 100);

    chk("result_error_exclusive", 16'(both_seen), 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/rpn_sequencer.md
# rpn_sequencer

Upstream command stage for `STACK_BASED_ALU`: evaluates a reverse-Polish expression supplied as a valid/ready token stream. For each token it issues the ALU opcode sequence needed, then pops the final value and presents it with a sticky overflow flag. It also tracks stack depth locally, so malformed expressions are rejected before the ALU underflows or overfills.

## Interface
- `N`, 4: operand/result width; must match the ALU.
- `MAX_SIZE`, 1024: ALU stack capacity; must match the ALU.
- `clk`  in  1: single clock, rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `tok_valid`  in  1: token present.
- `tok_ready`  out  1: token accepted when `tok_valid & tok_ready` at a rising edge.
- `tok_is_op`  in  1: 1 = operator, 0 = operand.
- `tok_op`  in  1: operator select; 0 = add, 1 = multiply.
- `tok_value`  in  N signed: operand value; ignored for operators.
- `tok_last`  in  1: final token of the expression.
- `alu_opcode`  out  3: to the ALU; 110 push, 111 pop, 100 add, 101 mul, 000 no-op.
- `alu_input_data`  out  N signed: push data to the ALU.
- `alu_output_data`  in  N signed: ALU result/pop data.
- `alu_overflow`  in  1: ALU arithmetic overflow.
- `alu_success`  in  1: ALU operation accepted.
- `result`  out  N signed: expression value; held until the next `result_valid`.
- `result_valid`  out  1: one-cycle completion pulse.
- `result_ovf`  out  1: OR of `alu_overflow` over all arithmetic in the expression; qualified by `result_valid`.
- `error`  out  1: one-cycle pulse in place of `result_valid`.
- `error_code`  out  2: 01 underflow, 10 stack full, 11 final depth ≠ 1, 00 ALU `success` low; held until the next pulse.

## Operation
- ALU add/mul do not modify the stack; they only drive `output_data`. An operator is therefore executed as: arith → capture → pop → pop → push(captured).
- The FSM has the following states.
  - IDLE: `tok_ready`=1, opcode 000.
  - Operand accepted:
    - If `depth==MAX_SIZE`, go to ERR_DRAIN with code 10.
    - Otherwise issue push of `tok_value` (PUSH state, 1 cycle) and increment depth.
  - Operator accepted:
    - If `depth<2`, go to ERR_DRAIN with code 01.
    - Otherwise ARITH → CAPT → POP_A → POP_B → PUSH_R, depth −1 net.
  - CAPT: drives opcode 000, latches `alu_output_data` into the temp register, and ORs `alu_overflow` into the sticky flag.
  - After a `tok_last` token completes:
    - If `depth≠1`, go to ERR_DRAIN with code 11.
    - Otherwise go FIN_POP → FIN_CAPT. `result` ← `alu_output_data`, pulse `result_valid`, depth 0, clear the sticky flag, return to IDLE.
  - In CAPT and FIN_CAPT, sampled `alu_success`=0 → ERR_DRAIN with code 00.
  - ERR_DRAIN: issue pops until depth 0, then go to ERR_SKIP.
  - ERR_SKIP: `tok_ready`=1, discard tokens up to and including `tok_last`. If the offending token was itself last, skip this state. Then pulse `error` and return to IDLE.
- Arithmetic is N-bit two's complement as performed by the ALU; the sequencer does no arithmetic. The depth counter is `$clog2(MAX_SIZE+1)` bits.

## Timing
- `tok_ready` is high only in IDLE and ERR_SKIP; it is combinational from state.
- Opcode and data are registered outputs. The ALU samples them on the next edge; its outputs are read one cycle later in the CAPT state.
- Latency per token:
  - operand: 1 cycle in PUSH, then back in IDLE;
  - operator: 5 cycles;
  - final FIN_POP/FIN_CAPT: +2 cycles.
- Reset values:
  - `alu_opcode`=000 and `alu_input_data`=0;
  - `tok_ready`=0 during reset, 1 in IDLE after reset;
  - `result`=0, `result_valid`=0, `result_ovf`=0, `error`=0, `error_code`=00;
  - depth 0, state IDLE.
- A reset mid-expression aborts immediately. The ALU is reset by the same `rst`, so no drain is needed.
- `result_valid` and `error` are never high together.

## Structure
- Shared package `stack_alu_pkg` holds:
  - the opcode constants (`OP_NOP`, `OP_ADD`, `OP_MUL`, `OP_PUSH`, `OP_POP`);
  - the `error_code` constants;
  - the FSM state enum.
- The ALU uses the same opcode constants.
- No sub-module is needed; a single FSM plus depth counter.

## Test plan
- N=4, tokens 3,4,+(last) → `result`=7, `result_ovf`=0; ALU depth 0 afterwards.
- Tokens 3,4,×(last) → `result`=−4 (12 wrapped to 4 bits), `result_ovf`=1.
- Tokens 2,3,+,5,×(last) → `result`=−7 (25 wrapped), `result_ovf`=1. Check `tok_ready` is low for 5 cycles after each operator.
- Tokens 5,+,7(last) → `error`, code 01. One pop drained; token 7 discarded. A following expression 1,1,+(last) → 2.
- Tokens 1,2(last) → `error`, code 11, two pops issued.
- Assert `rst` during POP_B of 3,4,+ → all outputs at reset values within the same cycle; the next expression evaluates correctly.
